// File: rtl/mult_sequencer_if.sv
`default_nettype none
// ============================================================================
// mult_sequencer_if : core <-> multiply sequencer operand/result bundle
// Rev 1.0
// ============================================================================
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   is_signed;
  logic [WIDTH-1:0]       opa;
  logic [WIDTH-1:0]       opb;
  logic                   stall;
  logic                   busy;
  logic                   done;
  logic                   fp_we;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, is_signed, opa, opb,
    input  stall, busy, done, fp_we, product
  );

  modport slave (
    input  start, is_signed, opa, opb,
    output stall, busy, done, fp_we, product
  );
endinterface
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// mult_sequencer : radix-2 shift-add sequencer for mult/multu, stalls the core
// Rev 1.0
// ============================================================================
module mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mult_sequencer_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [PW-1:0]     acc_q;
  logic              neg_q;
  logic [PW-1:0]     product_q;
  logic              busy_q;
  logic              done_q;

  logic [WIDTH-1:0]  opa_mag_d;
  logic [WIDTH-1:0]  opb_mag_d;
  logic [PW-1:0]     partial_d;
  logic [PW-1:0]     acc_d;
  logic [PW-1:0]     product_d;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exactly right when read unsigned.
  always_comb begin
    opa_mag_d = bus.opa;
    opb_mag_d = bus.opb;
    if (bus.is_signed && bus.opa[WIDTH-1]) opa_mag_d = ~bus.opa + WIDTH'(1);
    if (bus.is_signed && bus.opb[WIDTH-1]) opb_mag_d = ~bus.opb + WIDTH'(1);
  end

  always_comb begin
    partial_d = '0;
    if (mplier_q[0]) partial_d = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    acc_d     = acc_q + partial_d;
    product_d = neg_q ? (~acc_d + PW'(1)) : acc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q  <= opa_mag_d;
            mplier_q <= opb_mag_d;
            neg_q    <= bus.is_signed & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNTW'(1);
          // The final iteration's sum feeds the product directly so it is valid in DONE.
          if (cnt_q == LAST_CNT) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall   = ~reset & (((state_q == IDLE) & bus.start) | (state_q == RUN));
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fp_we   = done_q;
  assign bus.product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mult_sequencer : randomized self-checking bench against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_mult_sequencer;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at a sample point with the sequencer in IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit hold, input bit scramble);
    logic [63:0] exp;
    int stall_n, busy_n, done_n;
    exp = ref_mul(a, b, s);
    bus.start = 1'b1; bus.opa = a; bus.opb = b; bus.is_signed = s;
    #1;
    chk("stall_c0", 64'(bus.stall), 64'd1);
    chk("busy_c0",  64'(bus.busy),  64'd0);
    stall_n = 0; busy_n = 0; done_n = 0;
    for (int k = 1; k <= WIDTH; k++) begin
      step();
      if (!hold) bus.start = 1'b0;
      if (scramble) begin
        bus.opa = $urandom; bus.opb = $urandom; bus.is_signed = 1'($urandom_range(0, 1));
      end
      #1;
      stall_n += int'(bus.stall);
      busy_n  += int'(bus.busy);
      done_n  += int'(bus.done | bus.fp_we);
    end
    chk("run_stall_cycles", 64'(stall_n), 64'(WIDTH));
    chk("run_busy_cycles",  64'(busy_n),  64'(WIDTH));
    chk("run_early_done",   64'(done_n),  64'd0);
    step();
    chk("done_pulse", 64'(bus.done),  64'd1);
    chk("fp_we",      64'(bus.fp_we), 64'd1);
    chk("done_stall", 64'(bus.stall), 64'd0);
    chk("done_busy",  64'(bus.busy),  64'd1);
    chk("product",    bus.product,    exp);
    bus.start = 1'b0;
    step();
    chk("idle_busy",    64'(bus.busy),  64'd0);
    chk("idle_done",    64'(bus.done),  64'd0);
    chk("idle_stall",   64'(bus.stall), 64'd0);
    chk("product_hold", bus.product,    exp);
  endtask

  initial begin
    int done_at[$];
    int stall_low_at[$];
    int n;
    logic [31:0] a, b;
    n_checks = 0;
    n_errors = 0;

    reset = 1'b1;
    bus.start = 1'b1; bus.opa = 32'd7; bus.opb = 32'd3; bus.is_signed = 1'b0;
    step(); step();
    chk("rst_stall",   64'(bus.stall), 64'd0);
    chk("rst_busy",    64'(bus.busy),  64'd0);
    chk("rst_done",    64'(bus.done),  64'd0);
    chk("rst_fp_we",   64'(bus.fp_we), 64'd0);
    chk("rst_product", bus.product,    64'd0);
    bus.start = 1'b0;
    #2 reset = 1'b0;
    step();

    run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFFFFF9, 32'd6, 1'b1, 1'b1, 1'b0);
    run_op(32'hFFFFFFF9, 32'd6, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
    run_op(32'd0, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
    run_op(32'h80000000, 32'd1, 1'b1, 1'b0, 1'b1);

    // start held high continuously: two completions, no retrigger from DONE
    bus.start = 1'b1; bus.opa = 32'd2; bus.opb = 32'd9; bus.is_signed = 1'b0;
    for (int c = 0; c < 70; c++) begin
      #1;
      if (!bus.stall) stall_low_at.push_back(c);
      if (bus.done) begin
        done_at.push_back(c);
        chk("hold_product", bus.product, ref_mul(32'd2, 32'd9, 1'b0));
      end
      step();
    end
    chk("hold_done_count",  64'(done_at.size()), 64'd2);
    chk("hold_done_first",  64'(done_at.size() > 0 ? done_at[0] : -1), 64'd33);
    chk("hold_done_second", 64'(done_at.size() > 1 ? done_at[1] : -1), 64'd67);
    chk("hold_stall_low_count", 64'(stall_low_at.size()), 64'd2);
    chk("hold_stall_low_first", 64'(stall_low_at.size() > 0 ? stall_low_at[0] : -1), 64'd33);
    chk("hold_stall_low_second", 64'(stall_low_at.size() > 1 ? stall_low_at[1] : -1), 64'd67);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    chk("drain_idle", 64'(bus.busy), 64'd0);

    // asynchronous reset in the middle of RUN
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.opa = 32'd100; bus.opb = 32'd100; bus.is_signed = 1'b0;
    for (int k = 0; k < 10; k++) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",    64'(bus.busy),  64'd0);
    chk("arst_stall",   64'(bus.stall), 64'd0);
    chk("arst_product", bus.product,    64'd0);
    chk("arst_done",    64'(bus.done),  64'd0);
    bus.start = 1'b0;
    step();
    #2 reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      n += int'(bus.done | bus.fp_we | bus.busy);
    end
    chk("arst_no_resume", 64'(n), 64'd0);
    run_op(32'd4, 32'd4, 1'b0, 1'b0, 1'b0);

    // randomized operations, back-to-back, with operand churn during RUN
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: b = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
